// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: frame geometry, complex sample type,
// unloader FSM states and the base-4 digit-reversal helper.
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int FFT_W     = 32;
  localparam int FFT_LOG2N = 6;
  localparam int FFT_LOG4N = 3;

  typedef struct packed {
    logic [FFT_W-1:0] re;
    logic [FFT_W-1:0] im;
  } cplx_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } unl_state_t;

  // Reverses the order of the base-4 digits of k over FFT_LOG4N digits.
  function automatic logic [FFT_LOG2N-1:0] digit_rev4(input logic [FFT_LOG2N-1:0] k);
    logic [FFT_LOG2N-1:0] r;
    r = {FFT_LOG2N{1'b0}};
    for (int i = 0; i < FFT_LOG4N; i++) begin
      r[2*i +: 2] = k[2*(FFT_LOG4N-1-i) +: 2];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// N-entry complex frame register file: whole-frame parallel write, one
// combinational indexed read port.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int W  = FFT_W,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_re [N],
  input  logic [W-1:0]  i_wr_im [N],
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_re,
  output logic [W-1:0]  o_rd_im
);

  logic [W-1:0] r_re [N];
  logic [W-1:0] r_im [N];

  // Frame capture; storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < N; i++) begin
        r_re[i] <= i_wr_re[i];
        r_im[i] <= i_wr_im[i];
      end
    end
  end

  assign o_rd_re = r_re[i_rd_addr];
  assign o_rd_im = r_im[i_rd_addr];

endmodule

// File: rtl/fft_frame_unloader.sv
// Captures one parallel FFT output frame and streams it out one bin per beat.
// Optional macro DIGIT_REVERSE_EN: emit bins in natural order from a digit-reversed frame.
module fft_frame_unloader
  import fft_pkg::*;
#(
  parameter int N    = FFT_N,
  parameter int W    = FFT_W,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_re [N],
  input  logic [W-1:0]         in_im [N],
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_re,
  output logic [W-1:0]         out_im,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic [CNTW-1:0]      frame_cnt,
  output logic [CNTW-1:0]      overrun_cnt
);

  localparam int               LOG2N    = $clog2(N);
  localparam logic [LOG2N-1:0] IDX_ZERO = {LOG2N{1'b0}};
  localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);
  localparam logic [CNTW-1:0]  CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0]  CNT_MAX  = {CNTW{1'b1}};
  localparam logic [W-1:0]     DAT_ZERO = {W{1'b0}};

  unl_state_t       r_state;
  logic             r_out_valid;
  logic [W-1:0]     r_re;
  logic [W-1:0]     r_im;
  logic [LOG2N-1:0] r_idx;
  logic             r_last;
  logic [CNTW-1:0]  r_frame_cnt;
  logic [CNTW-1:0]  r_ovr_cnt;

  logic             w_beat;
  logic             w_in_ready;
  logic             w_capture;
  logic             w_overrun;
  logic [LOG2N-1:0] w_next_idx;
  logic [LOG2N-1:0] w_rd_addr;
  logic [W-1:0]     w_rd_re;
  logic [W-1:0]     w_rd_im;

  // Handshake decode; a new frame is accepted in IDLE or on the final beat.
  always_comb begin
    w_beat     = r_out_valid & out_ready;
    w_in_ready = (r_state == ST_IDLE) | (w_beat & r_last);
    w_capture  = in_valid & w_in_ready;
    w_overrun  = in_valid & ~w_in_ready;
    w_next_idx = r_idx + IDX_ONE;
  end

`ifdef DIGIT_REVERSE_EN
  // Digit reversal is defined over the package frame size.
  assign w_rd_addr = LOG2N'(digit_rev4(FFT_LOG2N'(w_next_idx)));
`else
  assign w_rd_addr = w_next_idx;
`endif

  fft_frame_buf #(
    .N (N),
    .W (W)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_capture),
    .i_wr_re   (in_re),
    .i_wr_im   (in_im),
    .i_rd_addr (w_rd_addr),
    .o_rd_re   (w_rd_re),
    .o_rd_im   (w_rd_im)
  );

  // Frame sequencing, output registers and counters. Beat 0 always maps to
  // bin 0 in either ordering, so it is taken straight from the input frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_re        <= DAT_ZERO;
      r_im        <= DAT_ZERO;
      r_idx       <= IDX_ZERO;
      r_last      <= 1'b0;
      r_frame_cnt <= CNT_ZERO;
      r_ovr_cnt   <= CNT_ZERO;
    end else begin
      if (w_overrun && (r_ovr_cnt != CNT_MAX)) begin
        r_ovr_cnt <= r_ovr_cnt + CNT_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_state     <= ST_STREAM;
            r_out_valid <= 1'b1;
            r_re        <= in_re[0];
            r_im        <= in_im[0];
            r_idx       <= IDX_ZERO;
            r_last      <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (w_beat) begin
            if (r_last) begin
              r_frame_cnt <= r_frame_cnt + CNT_ONE;
              if (w_capture) begin
                r_re   <= in_re[0];
                r_im   <= in_im[0];
                r_idx  <= IDX_ZERO;
                r_last <= 1'b0;
              end else begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b0;
                r_re        <= DAT_ZERO;
                r_im        <= DAT_ZERO;
                r_idx       <= IDX_ZERO;
                r_last      <= 1'b0;
              end
            end else begin
              r_re   <= w_rd_re;
              r_im   <= w_rd_im;
              r_idx  <= w_next_idx;
              r_last <= (w_next_idx == IDX_LAST);
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_re      = r_re;
  assign out_im      = r_im;
  assign out_idx     = r_idx;
  assign out_last    = r_last;
  assign frame_cnt   = r_frame_cnt;
  assign overrun_cnt = r_ovr_cnt;

endmodule

// File: tb/tb_fft_frame_unloader.sv
// Self-checking bench for fft_frame_unloader: random frames and ready patterns
// checked against a frame-level reference model.
module tb_fft_frame_unloader;
  import fft_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_re [64];
  logic [31:0] in_im [64];
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_re;
  logic [31:0] out_im;
  logic [5:0]  out_idx;
  logic        out_last;
  logic [15:0] frame_cnt;
  logic [15:0] overrun_cnt;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int exp_ovr = 0;

  cplx_t       m [64];
  cplx_t       nf [64];
  logic [31:0] rec_re [64];

  fft_frame_unloader dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_re       (in_re),
    .in_im       (in_im),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_re      (out_re),
    .out_im      (out_im),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .frame_cnt   (frame_cnt),
    .overrun_cnt (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int src_of(input int k);
`ifdef DIGIT_REVERSE_EN
    return (k % 4) * 16 + ((k / 4) % 4) * 4 + (k / 16);
`else
    return k;
`endif
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  task automatic rand_model();
    for (int i = 0; i < 64; i++) begin
      m[i].re = $urandom;
      m[i].im = $urandom;
    end
  endtask

  task automatic load_frame();
    for (int i = 0; i < 64; i++) begin
      in_re[i] = m[i].re;
      in_im[i] = m[i].im;
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Consumes beats; mode 0 ready=1, 1 pattern 1,0,0,1, 2 random.
  task automatic run_stream(input int mode, input int stop_after, input bit b2b, input int ovr_beat,
                            output int n_beats, output int n_cycles, output int data_err,
                            output int stall_err, output int rdy_err);
    bit stalled, hs, ovr_done, exp_rdy;
    logic [31:0] p_re, p_im;
    logic [5:0] p_idx;
    logic p_last;
    n_beats = 0; n_cycles = 0; data_err = 0; stall_err = 0; rdy_err = 0;
    stalled = 1'b0; ovr_done = 1'b0;
    p_re = 32'd0; p_im = 32'd0; p_idx = 6'd0; p_last = 1'b0;
    for (int c = 0; c < 600 && n_beats < stop_after; c++) begin
      if (stalled && (out_valid !== 1'b1 || out_re !== p_re || out_im !== p_im ||
                      out_idx !== p_idx || out_last !== p_last)) stall_err++;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = 1'b0;
      if (b2b && out_valid === 1'b1 && n_beats == 63 && out_ready) begin
        for (int i = 0; i < 64; i++) begin
          in_re[i] = nf[i].re;
          in_im[i] = nf[i].im;
        end
        in_valid = 1'b1;
      end
      if (!ovr_done && ovr_beat == n_beats && out_valid === 1'b1) begin
        for (int i = 0; i < 64; i++) begin
          in_re[i] = $urandom;
          in_im[i] = $urandom;
        end
        in_valid = 1'b1;
        ovr_done = 1'b1;
      end
      #1;
      hs = (out_valid === 1'b1) && out_ready;
      exp_rdy = (out_valid !== 1'b1) || (hs && n_beats == 63);
      if (in_ready !== exp_rdy) rdy_err++;
      if (hs) begin
        if (out_re !== m[src_of(n_beats)].re || out_im !== m[src_of(n_beats)].im ||
            out_idx !== 6'(n_beats) || out_last !== (n_beats == 63)) data_err++;
        rec_re[n_beats] = out_re;
        n_beats++;
        n_cycles = c + 1;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      p_re = out_re; p_im = out_im; p_idx = out_idx; p_last = out_last;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_re !== 32'd0 || out_im !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h/%0h want 0/0", out_re, out_im); end
    checks++; if (out_idx !== 6'd0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_idx_last: got %0d/%0b want 0/0", out_idx, out_last); end
    checks++; if (frame_cnt !== 16'd0 || overrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", frame_cnt, overrun_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single_frame();
    int nb, nc, de, se, re;
    for (int i = 0; i < 64; i++) begin
      m[i].re = i;
      m[i].im = 1000 + i;
    end
    out_ready = 1'b1;
    load_frame();
    checks++; if (out_valid !== 1'b1 || out_idx !== 6'd0) begin errors++; $display("FAIL single_latency: got valid=%0b idx=%0d want 1/0", out_valid, out_idx); end
    run_stream(0, 64, 1'b0, -1, nb, nc, de, se, re);
    exp_frames++;
    checks++; if (nb != 64 || nc != 64) begin errors++; $display("FAIL single_beats: got %0d beats in %0d cycles want 64/64", nb, nc); end
    checks++; if (de != 0) begin errors++; $display("FAIL single_data: got %0d bad beats want 0", de); end
    checks++; if (re != 0) begin errors++; $display("FAIL single_in_ready: got %0d bad cycles want 0", re); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_idle: got valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL single_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_order();
    logic [31:0] want [4];
`ifdef DIGIT_REVERSE_EN
    want[0] = 32'd16; want[1] = 32'd4; want[2] = 32'd36; want[3] = 32'd63;
`else
    want[0] = 32'd1; want[1] = 32'd4; want[2] = 32'd6; want[3] = 32'd63;
`endif
    checks++; if (rec_re[1] !== want[0]) begin errors++; $display("FAIL order_k1: got %0d want %0d", rec_re[1], want[0]); end
    checks++; if (rec_re[4] !== want[1]) begin errors++; $display("FAIL order_k4: got %0d want %0d", rec_re[4], want[1]); end
    checks++; if (rec_re[6] !== want[2]) begin errors++; $display("FAIL order_k6: got %0d want %0d", rec_re[6], want[2]); end
    checks++; if (rec_re[63] !== want[3]) begin errors++; $display("FAIL order_k63: got %0d want %0d", rec_re[63], want[3]); end
  endtask

  task automatic test_backpressure();
    int nb, nc, de, se, re;
    rand_model();
    load_frame();
    run_stream(1, 64, 1'b0, -1, nb, nc, de, se, re);
    exp_frames++;
    checks++; if (nb != 64 || nc != 128) begin errors++; $display("FAIL bp_cycles: got %0d beats in %0d cycles want 64/128", nb, nc); end
    checks++; if (de != 0) begin errors++; $display("FAIL bp_data: got %0d bad beats want 0", de); end
    checks++; if (se != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes want 0", se); end
    checks++; if (re != 0) begin errors++; $display("FAIL bp_in_ready: got %0d bad cycles want 0", re); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL bp_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_random_ready();
    int nb, nc, de, se, re;
    rand_model();
    load_frame();
    run_stream(2, 64, 1'b0, -1, nb, nc, de, se, re);
    exp_frames++;
    checks++; if (nb != 64 || de != 0 || se != 0 || re != 0) begin errors++; $display("FAIL rand_stream: got beats=%0d data=%0d stall=%0d ready=%0d want 64/0/0/0", nb, de, se, re); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL rand_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_back_to_back();
    int nb, nc, de, se, re;
    rand_model();
    for (int i = 0; i < 64; i++) begin
      nf[i].re = $urandom;
      nf[i].im = $urandom;
    end
    load_frame();
    run_stream(0, 64, 1'b1, -1, nb, nc, de, se, re);
    exp_frames++;
    checks++; if (nb != 64 || de != 0 || re != 0) begin errors++; $display("FAIL b2b_first: got beats=%0d data=%0d ready=%0d want 64/0/0", nb, de, re); end
    m = nf;
    checks++; if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_re !== m[0].re) begin errors++; $display("FAIL b2b_no_bubble: got valid=%0b idx=%0d re=%0h want 1/0/%0h", out_valid, out_idx, out_re, m[0].re); end
    run_stream(0, 64, 1'b0, -1, nb, nc, de, se, re);
    exp_frames++;
    checks++; if (nb != 64 || nc != 64 || de != 0) begin errors++; $display("FAIL b2b_second: got beats=%0d cycles=%0d data=%0d want 64/64/0", nb, nc, de); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_overrun();
    int nb, nc, de, se, re;
    rand_model();
    load_frame();
    run_stream(0, 64, 1'b0, 10, nb, nc, de, se, re);
    exp_ovr = sat_add(exp_ovr, 1);
    exp_frames++;
    checks++; if (nb != 64 || de != 0) begin errors++; $display("FAIL ovr_data: got beats=%0d bad=%0d want 64/0", nb, de); end
    checks++; if (re != 0) begin errors++; $display("FAIL ovr_in_ready: got %0d bad cycles want 0", re); end
    checks++; if (overrun_cnt !== 16'(exp_ovr)) begin errors++; $display("FAIL ovr_cnt: got %0d want %0d", overrun_cnt, exp_ovr); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL ovr_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_overrun_saturation();
    int nb, nc, de, se, re;
    rand_model();
    out_ready = 1'b1;
    load_frame();
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      in_re[i] = $urandom;
      in_im[i] = $urandom;
    end
    in_valid = 1'b1;
    repeat (65533) @(posedge clk);
    #1;
    exp_ovr = sat_add(exp_ovr, 65533);
    checks++; if (overrun_cnt !== 16'(exp_ovr)) begin errors++; $display("FAIL sat_below_max: got %0h want %0h", overrun_cnt, exp_ovr); end
    repeat (6) @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_ovr = sat_add(exp_ovr, 6);
    checks++; if (overrun_cnt !== 16'(exp_ovr)) begin errors++; $display("FAIL sat_max: got %0h want %0h", overrun_cnt, exp_ovr); end
    checks++; if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_re !== m[0].re) begin errors++; $display("FAIL sat_hold: got valid=%0b idx=%0d re=%0h want 1/0/%0h", out_valid, out_idx, out_re, m[0].re); end
    run_stream(0, 64, 1'b0, -1, nb, nc, de, se, re);
    exp_frames++;
    checks++; if (nb != 64 || de != 0) begin errors++; $display("FAIL sat_stream: got beats=%0d bad=%0d want 64/0", nb, de); end
  endtask

  task automatic test_reset_mid_stream();
    int nb, nc, de, se, re;
    rand_model();
    load_frame();
    run_stream(0, 30, 1'b0, -1, nb, nc, de, se, re);
    checks++; if (nb != 30 || de != 0 || out_idx !== 6'd30) begin errors++; $display("FAIL mid_pre: got beats=%0d bad=%0d idx=%0d want 30/0/30", nb, de, out_idx); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_frames = 0;
    exp_ovr = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_abort: got valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
    checks++; if (frame_cnt !== 16'(exp_frames) || overrun_cnt !== 16'(exp_ovr)) begin errors++; $display("FAIL mid_counters: got %0d/%0d want %0d/%0d", frame_cnt, overrun_cnt, exp_frames, exp_ovr); end
    checks++; if (out_idx !== 6'd0 || out_re !== 32'd0 || out_last !== 1'b0) begin errors++; $display("FAIL mid_outputs: got idx=%0d re=%0h last=%0b want 0/0/0", out_idx, out_re, out_last); end
    rand_model();
    load_frame();
    run_stream(0, 64, 1'b0, -1, nb, nc, de, se, re);
    exp_frames++;
    checks++; if (nb != 64 || de != 0) begin errors++; $display("FAIL mid_restart: got beats=%0d bad=%0d want 64/0", nb, de); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL mid_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_re[i] = 32'd0;
      in_im[i] = 32'd0;
      rec_re[i] = 32'd0;
    end
    test_reset();
    test_single_frame();
    test_order();
    test_backpressure();
    test_random_ready();
    test_back_to_back();
    test_overrun();
    test_overrun_saturation();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
